instr_sequencer: RTL

Fetch/issue sequencer that drives the control unit. It fetches instruction words from instruction memory, presents the 6-bit `opCode` to the combinational decoder, consumes the returned 8-bit control word, and then issues a one-cycle execute strobe. It also advances the PC through the conditional and unconditional branch, call and return opcodes, and stalls on multi-cycle ALU operations.

---
 rtl/instr_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// ============================================================================
// Module   : instr_sequencer
// Purpose  : fetch/decode/execute sequencer with branch, call/return and
//            ALU stall handling. Optional macro SEQ_RET_STACK_EN selects a
//            4-entry return stack instead of a single link register.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_sequencer #(
  parameter int PC_W = 10,
  parameter int IW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [IW-1:0]   imem_data,
  output logic [5:0]      opCode,
  input  logic [7:0]      ctrl,
  input  logic [3:0]      flags,
  input  logic            alu_busy,
  output logic            exec_en,
  output logic [9:0]      operand,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_STALL  = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic            imem_req_q, imem_req_d;
  logic            exec_en_q, exec_en_d;
  logic            halted_q, halted_d;
  logic            illegal_q, illegal_d;

`ifdef SEQ_RET_STACK_EN
  logic [PC_W-1:0] stk_q [4];
  logic [PC_W-1:0] stk_d [4];
  logic [2:0]      sp_q, sp_d;
`else
  logic [PC_W-1:0] link_q, link_d;
`endif

  logic [5:0]      w_op;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_fault;

  assign w_op     = ir_q[IW-1:IW-6];
  assign w_target = PC_W'(ir_q[9:0]);
  assign w_pc_inc = pc_q + PC_W'(1);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    w_fault   = 1'b0;
`ifdef SEQ_RET_STACK_EN
    stk_d     = stk_q;
    sp_d      = sp_q;
`else
    link_d    = link_q;
`endif

    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ctrl == 8'hFF) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else if (!ctrl[7]) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = (w_op >= 6'h10 && w_op <= 6'h12) ? S_STALL : S_FETCH;
        case (w_op)
          // brz/brn/brc/bro test flags[3]..flags[0] in opcode order
          6'h00, 6'h01, 6'h02, 6'h03:
            pc_d = flags[2'd3 - w_op[1:0]] ? w_target : w_pc_inc;
          6'h06: pc_d = w_target;
          6'h07: begin
`ifdef SEQ_RET_STACK_EN
            if (sp_q == 3'd4) begin
              w_fault = 1'b1;
            end else begin
              stk_d[sp_q[1:0]] = w_pc_inc;
              sp_d             = sp_q + 3'd1;
              pc_d             = w_target;
            end
`else
            link_d = w_pc_inc;
            pc_d   = w_target;
`endif
          end
          6'h08: begin
`ifdef SEQ_RET_STACK_EN
            if (sp_q == 3'd0) begin
              w_fault = 1'b1;
            end else begin
              pc_d = stk_q[sp_q[1:0] - 2'd1];
              sp_d = sp_q - 3'd1;
            end
`else
            pc_d = link_q;
`endif
          end
          default: pc_d = w_pc_inc;
        endcase
        if (w_fault) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_STALL:  if (!alu_busy) state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase

    // Outputs are registered, so they follow the state being entered
    imem_req_d = (state_d == S_FETCH);
    exec_en_d  = (state_d == S_EXEC);
    halted_d   = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      imem_req_q <= 1'b0;
      exec_en_q  <= 1'b0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
`ifdef SEQ_RET_STACK_EN
      for (int i = 0; i < 4; i++) stk_q[i] <= '0;
      sp_q       <= 3'd0;
`else
      link_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      imem_req_q <= imem_req_d;
      exec_en_q  <= exec_en_d;
      halted_q   <= halted_d;
      illegal_q  <= illegal_d;
`ifdef SEQ_RET_STACK_EN
      stk_q      <= stk_d;
      sp_q       <= sp_d;
`else
      link_q     <= link_d;
`endif
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign opCode    = w_op;
  assign operand   = ir_q[9:0];
  assign exec_en   = exec_en_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

endmodule

`default_nettype wire
